// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
// Shared definitions for the digit-serial adder: FSM state encoding and the
// digit-counter width helper.
package serial_adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ADD  = 1'b1
  } state_t;

  // One extra bit over ceil(log2(n)) so the counter can never wrap while an
  // operation is in flight, including n == 1.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if
// Request/result bundle of the serial adder.
//   master : drives start, A, B, c_in; observes busy, done, sum, c_out, overflow
//   slave  : the adder itself
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;

  modport master (
    output start, A, B, c_in,
    input  busy, done, sum, c_out, overflow
  );

  modport slave (
    input  start, A, B, c_in,
    output busy, done, sum, c_out, overflow
  );
endinterface

// File: rtl/serial_adder_digit_adder.sv
// digit_adder
// Combinational DIGIT-bit ripple-carry slice.
//   A, B   : operand digits
//   c_in   : carry into bit 0
//   sum    : digit result
//   c_out  : carry out of the top bit
//   c_msb  : carry into the top bit (for two's-complement overflow)
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] A,
  input  logic [DIGIT-1:0] B,
  input  logic             c_in,
  output logic [DIGIT-1:0] sum,
  output logic             c_out,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = c_in;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i]   = A[i] ^ B[i] ^ c[i];
      c[i+1]   = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
  end

  assign c_out = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// serial_adder
// Digit-serial adder: adds A + B + c_in over WIDTH/DIGIT clock steps,
// least significant digit first.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : request/result bundle (start, A, B, c_in -> busy, done, sum,
//           c_out, overflow)
//
// state | meaning
// IDLE  | waiting for start; result outputs hold the last result
// ADD   | one digit processed per clock, N steps in total
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_t             state_q;
  logic [WIDTH-1:0]   a_q, b_q, sum_q;
  logic [WIDTH-1:0]   a_d, b_d, sum_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q, c_out_q, ovf_q, busy_q, done_q;

  logic [DIGIT-1:0]       dsum;
  logic                   dcout, dcmsb;
  logic [WIDTH+DIGIT-1:0] sum_cat;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .A     (a_q[DIGIT-1:0]),
    .B     (b_q[DIGIT-1:0]),
    .c_in  (carry_q),
    .sum   (dsum),
    .c_out (dcout),
    .c_msb (dcmsb)
  );

  // Operands shift down so the current digit is always at bit 0; the result
  // shifts in from the top so it lands fully aligned after the last step.
  // The concatenation keeps the slice legal when DIGIT == WIDTH.
  assign a_d     = a_q >> DIGIT;
  assign b_d     = b_q >> DIGIT;
  assign sum_cat = {dsum, sum_q};
  assign sum_d   = sum_cat[WIDTH+DIGIT-1:DIGIT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.A;
            b_q     <= bus.B;
            carry_q <= bus.c_in;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ADD;
          end
        end
        ADD: begin
          a_q     <= a_d;
          b_q     <= b_d;
          sum_q   <= sum_d;
          carry_q <= dcout;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            c_out_q <= dcout;
            ovf_q   <= dcmsb ^ dcout;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.c_out    = c_out_q;
  assign bus.overflow = ovf_q;

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, total operand width in bits (legal values 2..64).
REQ-002 SHALL have parameter DIGIT, default 1, bits added per cycle; WIDTH mod DIGIT SHALL be 0.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, request to add; sampled only in IDLE.
REQ-006 SHALL have port A, input, WIDTH, first operand; sampled when start is accepted.
REQ-007 SHALL have port B, input, WIDTH, second operand; sampled when start is accepted.
REQ-008 SHALL have port c_in, input, 1, carry in; sampled when start is accepted.
REQ-009 SHALL have port busy, output, 1, high while an addition is in progress.
REQ-010 SHALL have port done, output, 1, single-cycle pulse marking a completed result.
REQ-011 SHALL have port sum, output, WIDTH, result of A+B+c_in modulo 2^WIDTH.
REQ-012 SHALL have port c_out, output, 1, unsigned carry out of bit WIDTH-1.
REQ-013 SHALL have port overflow, output, 1, two's-complement overflow: carry into MSB XOR c_out.

Function
REQ-014 SHALL implement states IDLE and ADD; N = WIDTH/DIGIT digit steps per operation.
REQ-015 IDLE with start=1 at edge t: SHALL latch A, B and c_in, clear digit counter, enter ADD.
REQ-016 IDLE with start=0: SHALL hold state and all outputs.
REQ-017 ADD: SHALL process digit k (bits k*DIGIT+DIGIT-1 .. k*DIGIT) at edges t+1 .. t+N, k = 0..N-1, least significant first.
REQ-018 Each step: SHALL add the operand digits plus the running carry and write the digit result into the sum register; carry register takes the digit carry out.
REQ-019 After edge t+N: SHALL return to IDLE, set done=1 for exactly one cycle, and present valid sum, c_out and overflow.
REQ-020 busy SHALL be 1 in the cycles following edges t .. t+N-1 and 0 from edge t+N onward.
REQ-021 sum, c_out and overflow SHALL hold their last result until the next accepted start; they are undefined while busy=1.
REQ-022 start while busy=1 SHALL be ignored; it is neither queued nor allowed to alter latched operands.
REQ-023 start=1 in the done cycle SHALL be accepted (back-to-back operations, N+1 cycles per result).
REQ-024 Changes on A, B and c_in after acceptance SHALL NOT affect the result in progress.
REQ-025 Digit counter SHALL be ceil(log2(N))+1 bits wide minimum, with no wrap within an operation; DIGIT=WIDTH gives a one-step operation.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, sum=0, c_out=0, overflow=0, counter=0, and clear the operand registers.
REQ-027 Reset asserted mid-operation SHALL abort it with no done pulse; the first start after rst_n rises SHALL be accepted normally.

Structure
REQ-028 State encoding (IDLE, ADD) SHALL reside in shared package serial_adder_pkg.
REQ-029 Sub-module digit_adder (parameter DIGIT; ports A, B, c_in, sum, c_out, c_msb) SHALL form the combinational DIGIT-bit ripple slice; c_msb is the carry into its top bit, used for overflow on the last step.

Verification
REQ-030 WIDTH=8, DIGIT=1: A=0xFF, B=0x01, c_in=0 -> sum=0x00, c_out=1, overflow=0, done 8 cycles after accept.
REQ-031 WIDTH=8, DIGIT=1: A=0x7F, B=0x01, c_in=0 -> sum=0x80, c_out=0, overflow=1.
REQ-032 WIDTH=8, DIGIT=4: A=0x3C, B=0x55, c_in=1 -> sum=0x92, c_out=0, done 2 cycles after accept.
REQ-033 start pulsed at cycles 3 and 5 after accept with different operands -> the second pulse is ignored and only the first result appears.
REQ-034 rst_n pulsed low at step 4 of 8 -> no done pulse and outputs zero; a new add of 0x10+0x20 then gives 0x30.
REQ-035 Random regression over WIDTH in {8,16,32} and all legal DIGIT values, with back-to-back starts -> every result matches A+B+c_in with exact N+1 throughput.
